// File: rtl/uart_command_receiver.sv
// UART 8N1 receiver that decodes single-character drive commands,
// with a watchdog that falls back to STOP when commands stop arriving.
module uart_command_receiver #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       uart_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic [2:0] command,
  output logic       cmd_valid,
  output logic       cmd_error,
  output logic       timeout
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic          sync1_q, rx_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          framing_error_q, framing_error_d;
  logic [2:0]    command_q, command_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          cmd_error_q, cmd_error_d;
  logic          timeout_q, timeout_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          hit;
  logic [2:0]    code;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync1_q         <= 1'b1;
      rx_q            <= 1'b1;
      state_q         <= S_IDLE;
      timer_q         <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      command_q       <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_error_q     <= 1'b0;
      timeout_q       <= 1'b0;
      wd_q            <= '0;
    end else begin
      sync1_q         <= uart_in;
      rx_q            <= sync1_q;
      state_q         <= state_d;
      timer_q         <= timer_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      data_out_q      <= data_out_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      command_q       <= command_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_error_q     <= cmd_error_d;
      timeout_q       <= timeout_d;
      wd_q            <= wd_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    data_out_d      = data_out_q;
    data_valid_d    = 1'b0;
    framing_error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_q) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        if (timer_q == HALF_END) begin
          timer_d = '0;
          idx_d   = '0;
          // a start bit gone high by mid-bit was only a glitch
          state_d = rx_q ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {rx_q, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (rx_q) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hit  = 1'b1;
    code = 3'd0;
    unique case (data_out_q)
      8'h53:   code = 3'd0;
      8'h46:   code = 3'd1;
      8'h42:   code = 3'd2;
      8'h4C:   code = 3'd3;
      8'h52:   code = 3'd4;
      default: hit  = 1'b0;
    endcase
  end

  always_comb begin
    command_d   = command_q;
    cmd_valid_d = 1'b0;
    cmd_error_d = 1'b0;
    timeout_d   = 1'b0;
    wd_d        = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    if (data_valid_q) begin
      if (hit) begin
        command_d   = code;
        cmd_valid_d = 1'b1;
      end else begin
        cmd_error_d = 1'b1;
      end
    end
    // a fresh command beats a simultaneous watchdog expiry
    if (cmd_valid_d) begin
      wd_d = '0;
    end else if (wd_q == WD_MAX && command_q != 3'd0) begin
      command_d = 3'd0;
      timeout_d = 1'b1;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;
  assign command       = command_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_error     = cmd_error_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_uart_command_receiver.sv
// Bench: a short-watchdog and a long-watchdog receiver share one serial
// line; frames are queued as sent and checked as each receiver reports them.
module tb_uart_command_receiver;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TO_SHORT = 1000;
  localparam int TO_LONG  = 25_000_000;

  typedef struct packed {
    logic       fe;
    logic [7:0] b;
  } frame_t;

  logic clk_50 = 1'b0;
  logic reset;
  logic uart_in;
  logic [1:0][7:0] dout;
  logic [1:0][2:0] cmd;
  logic [1:0] dv, fe, cv, ce, tmo;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc++;

  task automatic chk_eq(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_in(input string nm, input longint act,
                        input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // {hit, code} from the command character table
  function automatic logic [3:0] ref_decode(input logic [7:0] b);
    case (b)
      "S":     return {1'b1, 3'd0};
      "F":     return {1'b1, 3'd1};
      "B":     return {1'b1, 3'd2};
      "L":     return {1'b1, 3'd3};
      "R":     return {1'b1, 3'd4};
      default: return 4'b0000;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int T = (g == 0) ? TO_SHORT : TO_LONG;
    int rd = 0;
    int to_cnt = 0;
    int cv_cyc = 0;
    logic armed = 1'b0;
    logic pend = 1'b0;
    logic [7:0] pend_b = 8'h00;
    logic [2:0] mcmd = 3'd0;
    logic [7:0] last_good = 8'h00;

    uart_command_receiver #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD(BAUD),
      .TIMEOUT_CYCLES(T)
    ) dut (
      .clk_50(clk_50),
      .reset(reset),
      .uart_in(uart_in),
      .data_out(dout[g]),
      .data_valid(dv[g]),
      .framing_error(fe[g]),
      .command(cmd[g]),
      .cmd_valid(cv[g]),
      .cmd_error(ce[g]),
      .timeout(tmo[g])
    );

    always @(negedge clk_50) begin
      frame_t f;
      logic [3:0] dec;
      if (reset) begin
        pend      = 1'b0;
        armed     = 1'b0;
        mcmd      = 3'd0;
        last_good = 8'h00;
      end else begin
        if (tmo[g]) begin
          to_cnt++;
          chk_eq($sformatf("d%0d timeout armed", g), armed, 1);
          if (armed)
            chk_in($sformatf("d%0d timeout delay", g), cyc - cv_cyc, T - 1, T + 1);
          armed = 1'b0;
          mcmd  = 3'd0;
          chk_eq($sformatf("d%0d command after timeout", g), cmd[g], 0);
        end else if (armed && (cyc - cv_cyc) > T + 1) begin
          chk_eq($sformatf("d%0d timeout missing", g), tmo[g], 1);
          armed = 1'b0;
          mcmd  = 3'd0;
        end
        if (pend) begin
          dec = ref_decode(pend_b);
          chk_eq($sformatf("d%0d cmd_valid", g), cv[g], dec[3]);
          chk_eq($sformatf("d%0d cmd_error", g), ce[g], !dec[3]);
          if (dec[3]) begin
            mcmd   = dec[2:0];
            armed  = (dec[2:0] != 3'd0);
            cv_cyc = cyc;
          end
          chk_eq($sformatf("d%0d command", g), cmd[g], mcmd);
          pend = 1'b0;
        end else if (cv[g] || ce[g]) begin
          chk_eq($sformatf("d%0d stray cmd strobe", g), {cv[g], ce[g]}, 0);
        end
        if (dv[g] || fe[g]) begin
          if (rd >= exp_q.size()) begin
            chk_eq($sformatf("d%0d stray frame strobe", g), {dv[g], fe[g]}, 0);
          end else begin
            f = exp_q[rd];
            rd++;
            chk_eq($sformatf("d%0d framing_error", g), fe[g], f.fe);
            chk_eq($sformatf("d%0d data_valid", g), dv[g], !f.fe);
            if (!f.fe) begin
              chk_eq($sformatf("d%0d data_out", g), dout[g], f.b);
              chk_eq($sformatf("d%0d command held", g), cmd[g], mcmd);
              last_good = f.b;
              pend      = 1'b1;
              pend_b    = f.b;
            end else begin
              chk_eq($sformatf("d%0d data_out kept", g), dout[g], last_good);
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                            input int stop_bits);
    frame_t f;
    f.fe = !stop_ok;
    f.b  = b;
    exp_q.push_back(f);
    uart_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      wait_cyc(CPB);
    end
    uart_in = stop_ok;
    wait_cyc(CPB * stop_bits);
    uart_in = 1'b1;
    wait_cyc(CPB);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("d%0d %s data_out", i, tag), dout[i], 0);
      chk_eq($sformatf("d%0d %s command", i, tag), cmd[i], 0);
      chk_eq($sformatf("d%0d %s strobes", i, tag),
             {dv[i], fe[i], cv[i], ce[i], tmo[i]}, 0);
    end
  endtask

  initial begin
    repeat (200_000) @(posedge clk_50);
    $display("FAIL global cycle limit: got %0d, expected < 200000", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] tbl [5];
    logic [7:0] b;
    logic ok;
    int t0;
    tbl[0] = "S";
    tbl[1] = "F";
    tbl[2] = "B";
    tbl[3] = "L";
    tbl[4] = "R";
    uart_in = 1'b1;
    reset   = 1'b1;
    wait_cyc(5);
    chk_reset_outputs("power-on");
    reset = 1'b0;
    wait_cyc(50);

    send_frame("F", 1'b1, 1);
    wait_cyc(20);
    chk_eq("F data_out", dout[0], 8'h46);
    chk_eq("F command short", cmd[0], 1);
    chk_eq("F command long", cmd[1], 1);

    uart_in = 1'b0;
    wait_cyc(100);
    uart_in = 1'b1;
    wait_cyc(2 * CPB);

    send_frame(8'h52, 1'b0, 2);
    wait_cyc(CPB);
    chk_eq("after framing error data_out", dout[1], 8'h46);
    send_frame("B", 1'b1, 1);
    wait_cyc(20);
    chk_eq("B command long", cmd[1], 2);

    send_frame("L", 1'b1, 1);
    send_frame("X", 1'b1, 1);
    wait_cyc(20);
    chk_eq("X data_out", dout[1], 8'h58);
    chk_eq("X command kept long", cmd[1], 3);

    t0 = g_dut[0].to_cnt;
    send_frame("F", 1'b1, 1);
    wait_cyc(3000);
    chk_eq("watchdog strobes", g_dut[0].to_cnt - t0, 1);
    chk_eq("watchdog command short", cmd[0], 0);
    chk_eq("watchdog command long", cmd[1], 1);

    b = 8'hA5;
    uart_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_in = b[i];
      wait_cyc(CPB);
    end
    uart_in = b[4];
    wait_cyc(CPB / 2);
    reset   = 1'b1;
    uart_in = 1'b1;
    wait_cyc(3);
    chk_reset_outputs("mid-frame reset");
    reset = 1'b0;
    wait_cyc(2 * CPB);
    chk_reset_outputs("after release");
    send_frame("L", 1'b1, 1);
    wait_cyc(20);
    chk_eq("L after reset short", cmd[0], 3);
    chk_eq("L after reset long", cmd[1], 3);

    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 9) < 6)
        b = tbl[$urandom_range(0, 4)];
      else
        b = 8'($urandom);
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, ok, 1);
      wait_cyc($urandom_range(0, 300));
    end

    wait_cyc(2 * CPB);
    chk_eq("d0 frames reported", g_dut[0].rd, exp_q.size());
    chk_eq("d1 frames reported", g_dut[1].rd, exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
